// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one downstream dbus between the memory stage (port 0) and the page-table walker (port 1).
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  m0_req,
  output dbus_resp_t m0_resp,
  input  dbus_req_t  m1_req,
  output dbus_resp_t m1_resp,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic       busy
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic gnt, last, abandoned;
  dbus_req_t req_q;
  logic any_v, win, gnt_v, in_busy, sel, fwd;
  assign any_v   = m0_req.valid | m1_req.valid;
  assign win     = (m0_req.valid & m1_req.valid) ? (RR_EN ? ~last : 1'b0) : m1_req.valid;
  assign gnt_v   = gnt ? m1_req.valid : m0_req.valid;
  assign in_busy = state == BUSY;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (any_v & ~dresp.data_ok) ? BUSY : IDLE;
    else state_n = dresp.data_ok ? IDLE : BUSY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt       <= 1'b0;
      last      <= 1'b1;
      abandoned <= 1'b0;
      req_q     <= '0;
    end else if (state == IDLE) begin
      if (any_v & dresp.data_ok) last <= win;
      else if (any_v) begin
        req_q <= win ? m1_req : m0_req;
        gnt   <= win;
      end
    end else if (dresp.data_ok) begin
      last      <= gnt;
      abandoned <= 1'b0;
    end else if (!gnt_v) abandoned <= 1'b1;
  end
  // A granted port that drops valid mid-transaction stops seeing handshakes until IDLE.
  always_comb begin
    busy    = ~reset & in_busy;
    sel     = in_busy ? gnt : win;
    fwd     = ~reset & (in_busy ? (~abandoned & gnt_v) : any_v);
    dreq    = reset ? '0 : in_busy ? req_q : any_v ? (win ? m1_req : m0_req) : '0;
    m0_resp = '{addr_ok: fwd & ~sel & dresp.addr_ok, data_ok: fwd & ~sel & dresp.data_ok, data: dresp.data};
    m1_resp = '{addr_ok: fwd & sel & dresp.addr_ok, data_ok: fwd & sel & dresp.data_ok, data: dresp.data};
  end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed table and sequence checks for round-robin and fixed-priority arbiters.
module tb_dbus_arbiter;
  import dbus_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  dbus_req_t m0_req, m1_req, dreq_r, dreq_f;
  dbus_resp_t dresp, m0_r, m1_r, m0_f, m1_f;
  logic busy_r, busy_f;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  dbus_arbiter #(.RR_EN(1'b1)) u_rr (.clk(clk), .reset(reset), .m0_req(m0_req), .m0_resp(m0_r),
    .m1_req(m1_req), .m1_resp(m1_r), .dreq(dreq_r), .dresp(dresp), .busy(busy_r));
  dbus_arbiter #(.RR_EN(1'b0)) u_fp (.clk(clk), .reset(reset), .m0_req(m0_req), .m0_resp(m0_f),
    .m1_req(m1_req), .m1_resp(m1_f), .dreq(dreq_f), .dresp(dresp), .busy(busy_f));

  typedef struct {
    logic m0v, m1v, dok;
    logic rr_v; logic [31:0] rr_a; logic [1:0] rr_ok; logic rr_b;
    logic fp_v; logic [31:0] fp_a; logic [1:0] fp_ok; logic fp_b;
  } vec_t;
  localparam logic [31:0] A0 = 32'h8000_0010, A1 = 32'h0000_1000;
  vec_t vt [11];
  dbus_req_t ld0, ld1, st0, ld2;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m0_req = '0;
    m1_req = '0;
    dresp  = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    ld0 = '{valid: 1'b1, addr: A0, size: 3'd2, strobe: 4'h0, data: 32'h0};
    ld1 = '{valid: 1'b1, addr: A1, size: 3'd2, strobe: 4'h0, data: 32'h0};
    st0 = '{valid: 1'b1, addr: 32'h8000_0020, size: 3'd2, strobe: 4'h0F, data: 32'h1234_5678};
    ld2 = '{valid: 1'b1, addr: 32'h8000_0030, size: 3'd2, strobe: 4'h0, data: 32'h0};
    vt[0]  = '{1, 1, 0, 1, A0, 2'b00, 0, 1, A0, 2'b00, 0};
    vt[1]  = '{1, 1, 1, 1, A0, 2'b01, 1, 1, A0, 2'b01, 1};
    vt[2]  = '{1, 1, 0, 1, A1, 2'b00, 0, 1, A0, 2'b00, 0};
    vt[3]  = '{1, 1, 1, 1, A1, 2'b10, 1, 1, A0, 2'b01, 1};
    vt[4]  = '{1, 1, 0, 1, A0, 2'b00, 0, 1, A0, 2'b00, 0};
    vt[5]  = '{1, 1, 1, 1, A0, 2'b01, 1, 1, A0, 2'b01, 1};
    vt[6]  = '{0, 1, 0, 1, A1, 2'b00, 0, 1, A1, 2'b00, 0};
    vt[7]  = '{0, 1, 1, 1, A1, 2'b10, 1, 1, A1, 2'b10, 1};
    vt[8]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0};
    vt[9]  = '{1, 0, 1, 1, A0, 2'b01, 0, 1, A0, 2'b01, 0};
    vt[10] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0};
    m0_req = '0;
    m1_req = '0;
    dresp  = '0;
    next_cycle();
    @(negedge clk);
    chk("in_reset_valid", dreq_r.valid, 0);
    chk("in_reset_busy", busy_r, 0);
    do_reset();
    chk("reset_busy", busy_r, 0);
    chk("reset_dvalid", dreq_r.valid, 0);
    // arbitration order, both policies, plus same-cycle completion
    for (int i = 0; i < 11; i++) begin
      m0_req = vt[i].m0v ? ld0 : '0;
      m1_req = vt[i].m1v ? ld1 : '0;
      dresp  = '{addr_ok: 1'b0, data_ok: vt[i].dok, data: 32'h0};
      @(negedge clk);
      chk($sformatf("v%0d_rr_valid", i), dreq_r.valid, vt[i].rr_v);
      chk($sformatf("v%0d_rr_addr", i), dreq_r.addr, vt[i].rr_a);
      chk($sformatf("v%0d_rr_dok", i), {m1_r.data_ok, m0_r.data_ok}, vt[i].rr_ok);
      chk($sformatf("v%0d_rr_busy", i), busy_r, vt[i].rr_b);
      chk($sformatf("v%0d_fp_valid", i), dreq_f.valid, vt[i].fp_v);
      chk($sformatf("v%0d_fp_addr", i), dreq_f.addr, vt[i].fp_a);
      chk($sformatf("v%0d_fp_dok", i), {m1_f.data_ok, m0_f.data_ok}, vt[i].fp_ok);
      chk($sformatf("v%0d_fp_busy", i), busy_f, vt[i].fp_b);
      next_cycle();
    end
    // single load, data_ok on cycle 3
    do_reset();
    m0_req = ld0;
    dresp  = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
    @(negedge clk);
    chk("t1_c0_dreq", dreq_r, ld0);
    chk("t1_c0_m0_aok", m0_r.addr_ok, 1);
    chk("t1_c0_m1_aok", m1_r.addr_ok, 0);
    next_cycle();
    dresp = '0;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t1_c%0d_dreq", c), dreq_r, ld0);
      chk($sformatf("t1_c%0d_m0_dok", c), m0_r.data_ok, 0);
      chk($sformatf("t1_c%0d_busy", c), busy_r, 1);
      next_cycle();
    end
    dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'hDEAD_BEEF};
    @(negedge clk);
    chk("t1_c3_dreq", dreq_r, ld0);
    chk("t1_c3_m0_dok", m0_r.data_ok, 1);
    chk("t1_c3_m1_dok", m1_r.data_ok, 0);
    chk("t1_c3_m0_data", m0_r.data, 32'hDEAD_BEEF);
    chk("t1_c3_m1_data", m1_r.data, 32'hDEAD_BEEF);
    next_cycle();
    m0_req = '0;
    dresp  = '0;
    @(negedge clk);
    chk("t1_c4_busy", busy_r, 0);
    chk("t1_c4_dvalid", dreq_r.valid, 0);
    // abandoned store, then a fresh request from the same port
    do_reset();
    m0_req = st0;
    @(negedge clk);
    chk("t4_c0_dreq", dreq_r, st0);
    next_cycle();
    m0_req = '0;
    @(negedge clk);
    chk("t4_c1_dreq", dreq_r, st0);
    chk("t4_c1_busy", busy_r, 1);
    next_cycle();
    m0_req = ld2;
    for (int c = 2; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t4_c%0d_dreq", c), dreq_r, st0);
      chk($sformatf("t4_c%0d_m0_dok", c), m0_r.data_ok, 0);
      next_cycle();
    end
    dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
    @(negedge clk);
    chk("t4_c4_dreq", dreq_r, st0);
    chk("t4_c4_m0_dok", m0_r.data_ok, 0);
    chk("t4_c4_m0_aok", m0_r.addr_ok, 0);
    next_cycle();
    dresp = '0;
    @(negedge clk);
    chk("t4_c5_busy", busy_r, 0);
    chk("t4_c5_dreq", dreq_r, ld2);
    next_cycle();
    dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h0};
    @(negedge clk);
    chk("t4_c6_dreq", dreq_r, ld2);
    chk("t4_c6_m0_dok", m0_r.data_ok, 1);
    next_cycle();
    m0_req = '0;
    dresp  = '0;
    // reset while busy drops the transaction
    do_reset();
    m0_req = ld0;
    next_cycle();
    @(negedge clk);
    chk("t6_pre_busy", busy_r, 1);
    next_cycle();
    reset = 1'b1;
    dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h0};
    @(negedge clk);
    chk("t6_rst_m0_dok", m0_r.data_ok, 0);
    chk("t6_rst_dvalid", dreq_r.valid, 0);
    chk("t6_rst_busy", busy_r, 0);
    next_cycle();
    reset  = 1'b0;
    m0_req = '0;
    @(negedge clk);
    chk("t6_post_dvalid", dreq_r.valid, 0);
    chk("t6_post_busy", busy_r, 0);
    chk("t6_post_dok", {m1_r.data_ok, m0_r.data_ok}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
